divider_seq_8bits_8bits: RTL and testbench



---
 rtl/divider_seq_8bits_8bits.sv | 196 +++++++++++++++++++
 tb/tb_divider_seq_8bits_8bits.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_8bits_8bits.sv
`default_nettype none
// ============================================================================
//  Module   : divider_seq_8bits_8bits
//  Purpose  : Sequential radix-2 restoring divider with independent operand
//             signedness. Produces a quotient truncated toward zero and a
//             remainder carrying the dividend's sign, at a fixed latency of
//             A_chop_size+2 edges after the capture edge.
//  Ports    : clk         - sole clock, rising edge
//             reset_n     - synchronous, active-low reset
//             start       - request, accepted only while ready=1
//             A, A_sign   - dividend and its two's-complement flag
//             B, B_sign   - divisor and its two's-complement flag
//             ready       - high while idle
//             valid       - one-cycle pulse when Q/R/div_by_zero update
//             Q, R        - registered quotient / remainder
//             div_by_zero - set together with valid when the divisor was 0
//  Revision : 1.0 - initial release
// ============================================================================
module divider_seq_8bits_8bits #(
  parameter int A_chop_size = 8,
  parameter int B_chop_size = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [A_chop_size-1:0] A,
  input  logic [B_chop_size-1:0] B,
  input  logic                   A_sign,
  input  logic                   B_sign,
  output logic                   ready,
  output logic                   valid,
  output logic [A_chop_size-1:0] Q,
  output logic [B_chop_size-1:0] R,
  output logic                   div_by_zero
);

  localparam int CNT_W = $clog2(A_chop_size + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(A_chop_size - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  // Captured operands
  logic [A_chop_size-1:0]   a_q, a_d;
  logic [B_chop_size-1:0]   b_q, b_d;
  logic                     a_sign_q, a_sign_d;
  logic                     b_sign_q, b_sign_d;
  // Dividend magnitude; quotient bits shift in at the LSB as dividend bits
  // leave at the MSB, so after the last iteration it holds |q|.
  logic [A_chop_size-1:0]   dvd_q, dvd_d;
  logic [B_chop_size-1:0]   dvs_q, dvs_d;
  // Partial remainder between iterations is always < |B|, so B_chop_size
  // bits suffice for storage; the extra bit only exists after the shift.
  logic [B_chop_size-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     q_neg_q, q_neg_d;
  logic                     r_neg_q, r_neg_d;
  logic                     zero_q, zero_d;
  // Result registers
  logic [A_chop_size-1:0]   q_out_q, q_out_d;
  logic [B_chop_size-1:0]   r_out_q, r_out_d;
  logic                     dbz_q, dbz_d;
  logic                     valid_q, valid_d;

  // Datapath helpers
  logic                     a_neg, b_neg;
  logic [B_chop_size:0]     shifted;
  logic                     fits;
  logic [B_chop_size-1:0]   rem_sub;

  assign a_neg   = a_sign_q & a_q[A_chop_size-1];
  assign b_neg   = b_sign_q & b_q[B_chop_size-1];
  assign shifted = {rem_q, dvd_q[A_chop_size-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  // When the trial subtraction succeeds the true difference is < |B|, so the
  // modulo-2^B result below is exact.
  assign rem_sub = shifted[B_chop_size-1:0] - dvs_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    zero_d   = zero_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dbz_d    = dbz_q;
    valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          a_sign_d = A_sign;
          b_sign_d = B_sign;
          state_d  = PREP;
        end
      end

      PREP: begin
        dvd_d   = a_neg ? -a_q : a_q;
        dvs_d   = b_neg ? -b_q : b_q;
        q_neg_d = a_neg ^ b_neg;
        r_neg_d = a_neg;
        zero_d  = (b_q == '0);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ITER;
      end

      ITER: begin
        rem_d = fits ? rem_sub : shifted[B_chop_size-1:0];
        dvd_d = {dvd_q[A_chop_size-2:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (zero_q) begin
          q_out_d = '1;
          r_out_d = a_q[B_chop_size-1:0];
          dbz_d   = 1'b1;
        end else begin
          q_out_d = q_neg_q ? -dvd_q : dvd_q;
          r_out_d = r_neg_q ? -rem_q : rem_q;
          dbz_d   = 1'b0;
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      zero_q   <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      zero_q   <= zero_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
      dbz_q    <= dbz_d;
      valid_q  <= valid_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign valid       = valid_q;
  assign Q           = q_out_q;
  assign R           = r_out_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_seq_8bits_8bits.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_seq_8bits_8bits
//  Purpose  : Self-checking bench: directed vector table, random operands
//             against an arithmetic reference model, and hand-written
//             handshake / reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divider_seq_8bits_8bits;

  localparam int LAT = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       A_sign = 1'b0;
  logic       B_sign = 1'b0;
  logic       ready, valid, div_by_zero;
  logic [7:0] Q, R;

  int checks = 0;
  int errors = 0;

  divider_seq_8bits_8bits #(.A_chop_size(8), .B_chop_size(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .A(A), .B(B), .A_sign(A_sign), .B_sign(B_sign),
    .ready(ready), .valid(valid), .Q(Q), .R(R), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       as;
    logic       bs;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder
  // follows dividend sign), wrapped to 8 bits.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic as, input logic bs,
                       output logic [7:0] q, output logic [7:0] r, output logic dbz);
    int ai, bi, qi, ri;
    ai = as ? int'($signed(a)) : int'({24'd0, a});
    bi = bs ? int'($signed(b)) : int'({24'd0, b});
    if (bi == 0) begin
      q = 8'hFF; r = a; dbz = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q = qi[7:0]; r = ri[7:0]; dbz = 1'b0;
    end
  endtask

  // Called #1 after edge n0 of an operation; returns the edge index at which
  // valid is seen (-1 if never) and whether ready stayed low until then.
  task automatic wait_valid(input int n0, output int n, output bit rdy_ok);
    n = -1;
    rdy_ok = 1'b1;
    for (int i = n0 + 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        n = i;
        if (!ready) rdy_ok = 1'b0;
        return;
      end else if (ready) begin
        rdy_ok = 1'b0;
      end
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic as, input logic bs,
                       output int n, output bit rdy_ok);
    @(negedge clk);
    for (int i = 0; i < 30 && !ready; i++) @(negedge clk);
    start = 1'b1; A = a; B = b; A_sign = as; B_sign = bs;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble operands mid-operation; the result must not change.
    A = 8'($urandom); B = 8'($urandom); A_sign = 1'($urandom); B_sign = 1'($urandom);
    rdy_ok = !ready;
    wait_valid(0, n, rdy_ok);
    if (ready) rdy_ok = rdy_ok; // ready must be high in the valid cycle (checked in wait_valid)
  endtask

  task automatic check_out(input string tag, input logic [7:0] eq, input logic [7:0] er,
                           input logic edbz, input int n, input bit rdy_ok);
    chk({tag, ".latency"}, n, LAT);
    chk({tag, ".ready"}, rdy_ok, 1'b1);
    chk({tag, ".Q"}, Q, eq);
    chk({tag, ".R"}, R, er);
    chk({tag, ".dbz"}, div_by_zero, edbz);
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid) cnt++;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int n, nv;
    bit rok;
    logic [7:0] eq, er, ra, rb;
    logic edbz, ras, rbs;
    logic [7:0] bq_a[4], bq_b[4];
    logic bq_as[4], bq_bs[4];

    vecs[0] = '{8'd200, 8'd7,  1'b0, 1'b0, 8'h1C, 8'h04, 1'b0};
    vecs[1] = '{8'h9C,  8'h07, 1'b1, 1'b1, 8'hF2, 8'hFE, 1'b0};
    vecs[2] = '{8'hFF,  8'hFE, 1'b0, 1'b1, 8'h81, 8'h01, 1'b0};
    vecs[3] = '{8'h80,  8'hFF, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0};
    vecs[4] = '{8'h37,  8'h00, 1'b0, 1'b0, 8'hFF, 8'h37, 1'b1};
    vecs[5] = '{8'h64,  8'h0A, 1'b0, 1'b0, 8'h0A, 8'h00, 1'b0};
    vecs[6] = '{8'h80,  8'h80, 1'b1, 1'b1, 8'h01, 8'h00, 1'b0};
    vecs[7] = '{8'h7F,  8'hFF, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0};
    vecs[8] = '{8'hFF,  8'h01, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", ready, 1'b1);
    chk("rst.valid", valid, 1'b0);
    chk("rst.Q", Q, 8'h00);
    chk("rst.R", R, 8'h00);
    chk("rst.dbz", div_by_zero, 1'b0);
    reset_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, n, rok);
      check_out($sformatf("vec%0d", i), vecs[i].eq, vecs[i].er, vecs[i].edbz, n, rok);
    end

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ras = 1'($urandom); rbs = 1'($urandom);
      model(ra, rb, ras, rbs, eq, er, edbz);
      do_op(ra, rb, ras, rbs, n, rok);
      check_out($sformatf("rnd%0d", i), eq, er, edbz, n, rok);
    end

    // Back-to-back: start held high, operands replaced right after capture
    for (int k = 0; k < 4; k++) begin
      bq_a[k] = 8'($urandom); bq_b[k] = 8'($urandom_range(1, 255));
      bq_as[k] = 1'($urandom); bq_bs[k] = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b1; A = bq_a[0]; B = bq_b[0]; A_sign = bq_as[0]; B_sign = bq_bs[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;  // capture edge of operation k
      A = bq_a[k+1]; B = bq_b[k+1]; A_sign = bq_as[k+1]; B_sign = bq_bs[k+1];
      if (k == 2) start = 1'b0;
      wait_valid(0, n, rok);
      model(bq_a[k], bq_b[k], bq_as[k], bq_bs[k], eq, er, edbz);
      check_out($sformatf("b2b%0d", k), eq, er, edbz, n, rok);
    end

    // start pulsed while busy is ignored and not queued
    @(negedge clk);
    start = 1'b1; A = 8'd200; B = 8'd7; A_sign = 1'b0; B_sign = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; A = 8'd5; B = 8'd1;
    @(posedge clk); #1;  // edge 4
    start = 1'b0;
    wait_valid(4, n, rok);
    check_out("busy", 8'h1C, 8'h04, 1'b0, n, rok);
    count_valids(15, nv);
    chk("busy.noqueue", nv, 0);

    // Reset aborts an operation at e5
    @(negedge clk);
    start = 1'b1; A = 8'd200; B = 8'd7; A_sign = 1'b0; B_sign = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;  // e5
    chk("abort.ready", ready, 1'b1);
    chk("abort.valid", valid, 1'b0);
    chk("abort.Q", Q, 8'h00);
    chk("abort.R", R, 8'h00);
    chk("abort.dbz", div_by_zero, 1'b0);
    reset_n = 1'b1;
    count_valids(15, nv);
    chk("abort.novalid", nv, 0);
    do_op(8'd200, 8'd7, 1'b0, 1'b0, n, rok);
    check_out("after_abort", 8'h1C, 8'h04, 1'b0, n, rok);

    // Reset together with start: nothing captured
    @(negedge clk);
    reset_n = 1'b0; start = 1'b1; A = 8'd9; B = 8'd2;
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0;
    chk("rststart.ready", ready, 1'b1);
    count_valids(14, nv);
    chk("rststart.novalid", nv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
